// File: rtl/layer_priority_ctrl.sv
// Layer priority controller for the final pixel compositor.
// Double-buffered priority table (shadow/active) with frame-synchronous commit,
// per-layer blink gating, registered compositing and per-frame collision flags.
module layer_priority_ctrl #(
  parameter int NUM_LAYERS   = 4,
  parameter int RGB_W        = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layer_DR,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_RGB,
  input  logic [RGB_W-1:0]            backGroundRGB,
  input  logic [NUM_LAYERS-1:0]       blink_mask,
  input  logic                        cfg_valid,
  input  logic [1:0]                  cfg_slot,
  input  logic [1:0]                  cfg_layer,
  output logic                        cfg_ready,
  input  logic                        cfg_commit,
  output logic                        commit_pending,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [NUM_LAYERS-1:0]       collision_flags,
  output logic                        collision_valid
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              shadow_tbl [NUM_LAYERS];
  logic [1:0]              active_tbl [NUM_LAYERS];
  logic [CW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [NUM_LAYERS-1:0]   coll_acc;
  logic [NUM_LAYERS-1:0]   coll_hit;
  logic [NUM_LAYERS-1:0]   eff_req;
  logic [RGB_W-1:0]        pix_nxt;
  logic                    found;

  // Config FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Config FSM next state and handshake outputs; a commit seen in the
  // startOfFrame cycle only arms PENDING, so it lands on the following frame.
  always_comb begin
    state_nxt      = state;
    cfg_ready      = 1'b0;
    commit_pending = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_commit) state_nxt = PENDING;
      end
      PENDING: begin
        commit_pending = 1'b1;
        if (startOfFrame) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow writes while idle; active table reloads at the frame boundary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        shadow_tbl[i] <= 2'(i);
        active_tbl[i] <= 2'(i);
      end
    end else begin
      if (state == IDLE && cfg_valid) shadow_tbl[cfg_slot] <= cfg_layer;
      if (state == PENDING && startOfFrame) begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) active_tbl[i] <= shadow_tbl[i];
      end
    end
  end

  // Blink frame counter and phase.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (startOfFrame) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Priority scan: first active slot whose layer requests wins.
  always_comb begin
    eff_req = blink_phase ? (layer_DR & ~blink_mask) : layer_DR;
    pix_nxt = backGroundRGB;
    found   = 1'b0;
    for (int unsigned s = 0; s < NUM_LAYERS; s++) begin
      if (!found && eff_req[active_tbl[s]]) begin
        found   = 1'b1;
        pix_nxt = layer_RGB[active_tbl[s]*RGB_W +: RGB_W];
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) RGBOut <= '0;
    else         RGBOut <= pix_nxt;
  end

  // Per-layer overlap of the raw requests in this cycle.
  always_comb begin
    coll_hit = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      coll_hit[i] = layer_DR[i] & (|(layer_DR & ~(NUM_LAYERS'(1) << i)));
    end
  end

  // Collision accumulation; the startOfFrame pixel is deliberately not accumulated.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coll_acc        <= '0;
      collision_flags <= '0;
      collision_valid <= 1'b0;
    end else if (startOfFrame) begin
      collision_flags <= coll_acc;
      coll_acc        <= '0;
      collision_valid <= 1'b1;
    end else begin
      coll_acc        <= coll_acc | coll_hit;
      collision_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Self-checking bench for layer_priority_ctrl: directed steps then random
// traffic, all compared against a frame-level behavioural model.
module tb_layer_priority_ctrl;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [3:0]  layer_DR;
  logic [31:0] layer_RGB;
  logic [7:0]  backGroundRGB;
  logic [3:0]  blink_mask;
  logic        cfg_valid;
  logic [1:0]  cfg_slot;
  logic [1:0]  cfg_layer;
  logic        cfg_ready;
  logic        cfg_commit;
  logic        commit_pending;
  logic [7:0]  RGBOut;
  logic [3:0]  collision_flags;
  logic        collision_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_act [4];
  int         m_sh  [4];
  bit         m_pend;
  int         m_sof;
  logic [3:0] m_acc, m_flags;
  logic       m_valid;
  logic [7:0] m_rgb;

  layer_priority_ctrl #(.NUM_LAYERS(4), .RGB_W(8), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .layer_DR(layer_DR), .layer_RGB(layer_RGB), .backGroundRGB(backGroundRGB),
    .blink_mask(blink_mask), .cfg_valid(cfg_valid), .cfg_slot(cfg_slot),
    .cfg_layer(cfg_layer), .cfg_ready(cfg_ready), .cfg_commit(cfg_commit),
    .commit_pending(commit_pending), .RGBOut(RGBOut),
    .collision_flags(collision_flags), .collision_valid(collision_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = i;
      m_sh[i]  = i;
    end
    m_pend = 0; m_sof = 0; m_acc = '0; m_flags = '0; m_valid = 1'b0; m_rgb = '0;
  endtask

  // Winner: highest-priority table slot whose layer is visible this frame.
  function automatic logic [7:0] model_pixel();
    bit         blanked = ((m_sof / BF) % 2) == 1;
    logic [7:0] col;
    for (int s = 0; s < 4; s++) begin
      int l = m_act[s];
      if (layer_DR[l] && !(blanked && blink_mask[l])) begin
        col = layer_RGB[8*l +: 8];
        return col;
      end
    end
    return backGroundRGB;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    m_rgb = model_pixel();
    if (startOfFrame) begin
      m_flags = m_acc; m_acc = '0; m_valid = 1'b1; m_sof++;
    end else begin
      if ($countones(layer_DR) >= 2) m_acc = m_acc | layer_DR;
      m_valid = 1'b0;
    end
    if (!m_pend) begin
      if (cfg_valid) m_sh[cfg_slot] = cfg_layer;
      if (cfg_commit) m_pend = 1;
    end else if (startOfFrame) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    #1;
    check("rgb", RGBOut, m_rgb);
    check("ready", cfg_ready, !m_pend);
    check("pending", commit_pending, m_pend);
    check("coll_valid", collision_valid, m_valid);
    check("coll_flags", collision_flags, m_flags);
  endtask

  task automatic sof();
    startOfFrame = 1'b1; cycle(); startOfFrame = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] slot, input logic [1:0] layer, input logic commit);
    cfg_valid = 1'b1; cfg_slot = slot; cfg_layer = layer; cfg_commit = commit;
    cycle();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    check("rst_rgb", RGBOut, 8'h00);
    check("rst_pending", commit_pending, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_flags", collision_flags, 4'h0);
    check("rst_valid", collision_valid, 1'b0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    startOfFrame = 0; layer_DR = '0; layer_RGB = '0; backGroundRGB = 8'h03;
    blink_mask = '0; cfg_valid = 0; cfg_slot = '0; cfg_layer = '0; cfg_commit = 0;
    do_reset();

    // Default order: layer1 beats layer2
    layer_DR = 4'b0110; layer_RGB = {8'h55, 8'hE0, 8'h1C, 8'hAA};
    cycle();
    check("default_order", RGBOut, 8'h1C);
    layer_DR = 4'b0000;
    cycle();
    check("background", RGBOut, 8'h03);

    // Reprogram slot0=2, slot2=0; stays old order until the frame boundary
    layer_DR = 4'b0110;
    cfg_write(2'd0, 2'd2, 1'b0);
    cfg_write(2'd2, 2'd0, 1'b0);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    check("ready_drop", cfg_ready, 1'b0);
    cycle();
    check("held_order", RGBOut, 8'h1C);
    sof();
    cycle();
    check("new_order", RGBOut, 8'hE0);
    check("ready_back", cfg_ready, 1'b1);

    // Write+commit in the startOfFrame cycle; write during PENDING dropped
    layer_DR = 4'b1100;
    startOfFrame = 1'b1;
    cfg_write(2'd0, 2'd3, 1'b1);
    startOfFrame = 1'b0;
    cycle();
    check("no_early_load", RGBOut, 8'hE0);
    cfg_write(2'd0, 2'd1, 1'b0);
    layer_DR = 4'b1110;
    sof();
    cycle();
    check("second_sof_load", RGBOut, 8'h55);

    // Collision: one overlapping pixel mid-frame
    layer_DR = 4'b0000;
    sof();
    cycle();
    layer_DR = 4'b0101; cycle();
    layer_DR = 4'b0000; cycle();
    sof();
    check("coll_flags_set", collision_flags, 4'b0101);
    check("coll_pulse", collision_valid, 1'b1);
    cycle();
    check("coll_pulse_end", collision_valid, 1'b0);
    sof();
    check("coll_cleared", collision_flags, 4'b0000);

    // Reset while a commit is pending
    layer_DR = 4'b0110; layer_RGB = {8'h55, 8'hE0, 8'h1C, 8'hAA};
    cfg_write(2'd0, 2'd3, 1'b1);
    check("pending_set", commit_pending, 1'b1);
    #2;
    do_reset();
    sof();
    cycle();
    check("reset_default_order", RGBOut, 8'h1C);

    // Blink: layer0 for frames 0-1, background 2-3, layer0 4-5
    do_reset();
    blink_mask = 4'b0001; layer_DR = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      cycle();
      check("blink", RGBOut, ((f / 2) % 2) ? 8'h03 : 8'hAA);
      sof();
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      layer_DR      = 4'($urandom);
      layer_RGB     = $urandom;
      backGroundRGB = 8'($urandom);
      blink_mask    = 4'($urandom);
      cfg_valid     = ($urandom_range(3) == 0);
      cfg_slot      = 2'($urandom);
      cfg_layer     = 2'($urandom);
      cfg_commit    = ($urandom_range(11) == 0);
      startOfFrame  = ($urandom_range(15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_priority_ctrl.md
Name: layer_priority_ctrl

Overview:
- Frame-synchronous controller for the final pixel compositor.
- Selects which of NUM_LAYERS drawing layers wins each pixel, using a runtime-reprogrammable priority table.
- Priority changes take effect only at frame boundaries, so no frame ever shows a mix of old and new ordering.
- Also applies per-layer blink gating and latches per-frame layer-overlap (collision) flags for game logic.

Parameters:
- NUM_LAYERS, 4, number of drawing layers; fixed at 4 (2-bit indices).
- RGB_W, 8, colour width per pixel.
- BLINK_FRAMES, 16, frames per blink half-period; must be at least 1.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at frame start, asserted only outside the active area.
- layer_DR  in  NUM_LAYERS  per-layer drawing request; bit i belongs to layer i.
- layer_RGB  in  NUM_LAYERS*RGB_W  packed colours; layer i occupies bits [i*RGB_W +: RGB_W].
- backGroundRGB  in  RGB_W  colour used when no layer wins.
- blink_mask  in  NUM_LAYERS  layers subject to blinking.
- cfg_valid  in  1  write request into the shadow priority table.
- cfg_slot  in  2  priority slot to write; slot 0 is the highest priority.
- cfg_layer  in  2  layer index to place in cfg_slot.
- cfg_ready  out  1  write/commit accepted this cycle.
- cfg_commit  in  1  request to load shadow into active at the next startOfFrame.
- commit_pending  out  1  commit is waiting for a frame boundary.
- RGBOut  out  RGB_W  composited pixel, registered.
- collision_flags  out  NUM_LAYERS  bit i = layer i overlapped any other layer during the previous frame.
- collision_valid  out  1  one-cycle pulse when collision_flags is updated.

Behaviour:
- Reset state:
  - shadow and active tables = {slot0:0, slot1:1, slot2:2, slot3:3}.
  - RGBOut=0, collision_flags=0, collision_valid=0, commit_pending=0.
  - Blink counter=0, blink phase=0, collision accumulator=0.
  - Reset mid-PENDING discards the pending commit and the shadow contents.
- FSM states IDLE and PENDING:
  - cfg_ready = (state==IDLE).
  - commit_pending = (state==PENDING).
  - IDLE: cfg_valid=1 writes shadow[cfg_slot] <= cfg_layer.
  - IDLE: cfg_commit=1 moves to PENDING.
  - Same-cycle cfg_valid and cfg_commit: the write is included in the commit.
  - Commit asserted in the same cycle as startOfFrame: still goes to PENDING; it loads at the next startOfFrame, never the current one.
  - PENDING: cfg_valid and cfg_commit are ignored and have no effect.
  - PENDING and startOfFrame: active <= shadow, state returns to IDLE.
- Duplicate layer entries in the table are legal:
  - Only the highest-priority occurrence of a layer matters.
  - A layer absent from the active table is never drawn, but still contributes to collision detection.
- Blink:
  - Counter increments on each startOfFrame.
  - At BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
  - While phase=1, the effective request for each layer = layer_DR & ~blink_mask; otherwise effective request = layer_DR.
- Compositing:
  - Scan slots 0..3 and take the first slot whose layer has its effective request set; RGBOut <= that layer's RGB.
  - If no slot matches, RGBOut <= backGroundRGB.
  - Latency is exactly 1 clk from inputs to RGBOut.
  - Uses the active table only; shadow has no effect until committed.
- Collision detection:
  - Uses raw layer_DR, unaffected by blink or priority.
  - Each cycle, accumulator[i] |= layer_DR[i] & (OR of the other bits of layer_DR).
  - On startOfFrame: collision_flags <= accumulator, accumulator <= 0, collision_valid=1 in the following cycle only.
  - The pixel sampled in the startOfFrame cycle is not accumulated.

Test Plan:
- Default order:
  - Stimulus: layer_DR=4'b0110, layer1 RGB=8'h1C, layer2 RGB=8'hE0.
  - Response: one clk later RGBOut=8'h1C.
  - Then layer_DR=0 gives backGroundRGB=8'h03 after 1 clk.
- Reprogram and commit:
  - Stimulus: write slot0=2 and slot2=0, pulse cfg_commit; cfg_ready drops to 0.
  - Response: RGBOut stays 8'h1C until startOfFrame; afterwards the same inputs give 8'hE0, and cfg_ready returns to 1.
- Commit with startOfFrame in the same cycle, plus writes while PENDING:
  - Response: no change at that frame; the change lands at the second startOfFrame.
  - A cfg_valid issued during PENDING is dropped (shadow unchanged).
- Blink, BLINK_FRAMES=2, blink_mask=4'b0001, layer_DR=4'b0001:
  - Response: RGBOut follows layer0 for frames 0-1, background for frames 2-3, layer0 again for frames 4-5.
- Collision:
  - Stimulus: layer_DR=4'b0101 for 1 cycle mid-frame, then startOfFrame.
  - Response: collision_flags=4'b0101 with a single collision_valid pulse.
  - At the next frame with no overlap, flags=4'b0000.
- Reset in PENDING:
  - Stimulus: assert resetN=0 asynchronously while a commit is pending.
  - Response: RGBOut=0 immediately, commit_pending=0, default order restored.
  - The subsequent startOfFrame applies no commit.
